// File: rtl/osc_freq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osc_freq_pkg
// Description : Shared types, constants and saturating-increment helper for
//               the ring-oscillator frequency counter.
// Revision    : 1.0 - initial release
// ============================================================================
package osc_freq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    // Helper arithmetic runs at this width; callers zero-extend narrower counts.
    localparam int ACC_WIDTH = 32;
    localparam logic [ACC_WIDTH-1:0] CNT_MAX = '1;

    // Returns {ovf, acc'}: acc' sticks at limit and ovf flags an increment at limit.
    function automatic logic [ACC_WIDTH:0] sat_inc(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [ACC_WIDTH-1:0] limit
    );
        if (acc >= limit) begin
            return {1'b1, limit};
        end
        return {1'b0, acc + ACC_WIDTH'(1)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_sync_detect.sv
`default_nettype none
// ============================================================================
// Module      : edge_sync_detect
// Description : Multi-flop synchroniser with rising-edge detector; clear
//               suppresses the edge while the history is being reloaded.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic clear,
    output logic edge_out,
    output logic level_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level_out = r_sync[SYNC_STAGES-1];
    assign edge_out  = level_out & ~r_prev & ~clear;

endmodule
`default_nettype wire

// File: rtl/osc_freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : osc_freq_counter
// Description : Gated rising-edge counter measuring a ring oscillator over a
//               programmable clk window; single-shot or continuous.
// Revision    : 1.0 - initial release
// ============================================================================
module osc_freq_counter
    import osc_freq_pkg::*;
#(
    parameter int CNT_WIDTH   = 8,
    parameter int GATE_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  osc_in,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [GATE_WIDTH-1:0] gate_len,
    input  logic                  stop,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  valid,
    output logic                  overflow
);

    localparam logic [ACC_WIDTH-1:0] c_cnt_limit = CNT_MAX >> (ACC_WIDTH - CNT_WIDTH);

    state_e                r_state;
    logic [GATE_WIDTH-1:0] r_timer;
    logic [CNT_WIDTH-1:0]  r_acc;
    logic                  r_ovf;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overflow;
    logic                  r_valid;
    logic                  r_busy;

    logic                  w_edge;
    logic                  w_level;
    logic [ACC_WIDTH:0]    w_sat_res;
    logic [CNT_WIDTH-1:0]  w_acc_upd;
    logic                  w_ovf_upd;
    logic [GATE_WIDTH-1:0] w_gate_eff;

    edge_sync_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk       (clk),
        .rst       (rst),
        .async_in  (osc_in),
        .clear     (r_state == ARM),
        .edge_out  (w_edge),
        .level_out (w_level)
    );

    assign w_sat_res  = sat_inc(ACC_WIDTH'(r_acc), c_cnt_limit);
    assign w_acc_upd  = w_edge ? CNT_WIDTH'(w_sat_res) : r_acc;
    assign w_ovf_upd  = r_ovf | (w_edge & w_sat_res[ACC_WIDTH]);
    // A zero-length window would never terminate, so it runs as one cycle.
    assign w_gate_eff = (gate_len == '0) ? GATE_WIDTH'(1) : gate_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_timer <= w_gate_eff;
                        r_state <= ARM;
                        r_busy  <= 1'b1;
                    end
                end
                ARM: begin
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                    if (stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_timer == GATE_WIDTH'(1)) begin
                        // The boundary cycle's edge closes out the old window.
                        r_count    <= w_acc_upd;
                        r_overflow <= w_ovf_upd;
                        r_valid    <= 1'b1;
                        r_acc      <= '0;
                        r_ovf      <= 1'b0;
                        if (continuous) begin
                            r_timer <= w_gate_eff;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_acc   <= w_acc_upd;
                        r_ovf   <= w_ovf_upd;
                        r_timer <= r_timer - GATE_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign count    = r_count;
    assign valid    = r_valid;
    assign overflow = r_overflow;

    logic w_unused;
    assign w_unused = w_level;

endmodule
`default_nettype wire

// File: tb/tb_osc_freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_osc_freq_counter
// Description : Directed self-checking bench with a window-level scoreboard
//               for osc_freq_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osc_freq_counter;

    localparam int SYNC = 2;
    localparam int CMAX = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        osc_in = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] gate_len = '0;
    logic        stop = 1'b0;
    logic        busy;
    logic [7:0]  count;
    logic        valid;
    logic        overflow;

    osc_freq_counter #(
        .CNT_WIDTH   (8),
        .GATE_WIDTH  (16),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .osc_in     (osc_in),
        .start      (start),
        .continuous (continuous),
        .gate_len   (gate_len),
        .stop       (stop),
        .busy       (busy),
        .count      (count),
        .valid      (valid),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Posedge counter and record of what the DUT sampled on osc_in at each edge.
    int   cyc = 0;
    logic osc_hist [0:8191];
    always @(posedge clk) begin
        cyc = cyc + 1;
        osc_hist[cyc] = osc_in;
    end

    // Oscillator: half_per = clk cycles per level, 0 = hold osc_lvl.
    int   half_per = 0;
    logic osc_lvl = 1'b0;
    int   ph = 0;
    always @(negedge clk) begin
        if (half_per == 0) begin
            osc_in = osc_lvl;
        end else begin
            ph = ph + 1;
            if (ph >= half_per) begin
                ph = 0;
                osc_in = ~osc_in;
            end
        end
    end

    // Window-level model: a window processed at edges [first,last] reports
    // after edge last. A rise on osc_in is seen SYNC edges late.
    typedef struct {
        int vcyc;
        int first;
        int last;
    } win_t;
    win_t exp_q[$];
    int   busy_lo = 0;
    int   busy_hi = -1;
    int   last_count = 0;
    bit   last_ovf = 1'b0;

    function automatic int edges_in(input int a, input int b);
        int n = 0;
        for (int j = a; j <= b; j++) begin
            if (j - SYNC - 1 >= 0 && osc_hist[j-SYNC] === 1'b1 && osc_hist[j-SYNC-1] === 1'b0) n++;
        end
        return n;
    endfunction

    always @(negedge clk) begin
        int n;
        int e_cnt;
        bit e_ovf;
        if (exp_q.size() > 0 && exp_q[0].vcyc == cyc) begin
            n = edges_in(exp_q[0].first, exp_q[0].last);
            e_cnt = (n > CMAX) ? CMAX : n;
            e_ovf = (n > CMAX);
            check("m_valid", 64'(valid), 64'(1));
            check("m_count", 64'(count), 64'(e_cnt));
            check("m_overflow", 64'(overflow), 64'(e_ovf));
            last_count = e_cnt;
            last_ovf = e_ovf;
            void'(exp_q.pop_front());
        end else begin
            check("m_valid", 64'(valid), 64'(0));
            check("m_count", 64'(count), 64'(last_count));
            check("m_overflow", 64'(overflow), 64'(last_ovf));
        end
        check("m_busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
    end

    // Start is sampled at edge s; window i is processed at edges
    // s+2+(i-1)*N .. s+1+i*N and busy is high after edges s .. s+k*N.
    task automatic run(input int n, input bit cont, input int k, output int s);
        int eff;
        win_t w;
        eff = (n == 0) ? 1 : n;
        @(negedge clk);
        start = 1'b1;
        gate_len = 16'(n);
        continuous = cont;
        s = cyc + 1;
        for (int i = 1; i <= k; i++) begin
            w.first = s + 2 + (i - 1) * eff;
            w.last  = s + 1 + i * eff;
            w.vcyc  = w.last;
            exp_q.push_back(w);
        end
        busy_lo = s;
        busy_hi = s + k * eff;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_valid timeout actual=none required=valid within %0d cycles", limit);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int s;
        int v;
        int v2;
        int nv;

        repeat (3) @(negedge clk);
        check("rst_count", 64'(count), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        half_per = 1;
        repeat (6) @(negedge clk);

        // 1: toggle every clk, gate 10 -> 5 edges, valid 12 cycles after start cycle
        run(10, 1'b0, 1, s);
        wait_valid(40, v);
        check("t1_latency", 64'(v - s), 64'(11));
        check("t1_count", 64'(count), 64'(5));
        check("t1_overflow", 64'(overflow), 64'(0));
        @(negedge clk);
        check("t1_busy_after", 64'(busy), 64'(0));

        // 2: saturation then clean run
        run(600, 1'b0, 1, s);
        wait_valid(700, v);
        check("t2_count_sat", 64'(count), 64'(255));
        check("t2_overflow", 64'(overflow), 64'(1));
        run(20, 1'b0, 1, s);
        wait_valid(40, v);
        check("t2_count", 64'(count), 64'(10));
        check("t2_overflow_clr", 64'(overflow), 64'(0));

        // 3: continuous, period-4 oscillator, continuous dropped inside window 3
        half_per = 2;
        repeat (4) @(negedge clk);
        run(8, 1'b1, 3, s);
        wait_valid(20, v);
        check("t3_first_lat", 64'(v - s), 64'(9));
        check("t3_count1", 64'(count), 64'(2));
        wait_valid(20, v2);
        check("t3_spacing", 64'(v2 - v), 64'(8));
        check("t3_count2", 64'(count), 64'(2));
        wait_until(s + 19);
        continuous = 1'b0;
        wait_valid(20, v);
        check("t3_spacing3", 64'(v - v2), 64'(8));
        check("t3_count3", 64'(count), 64'(2));
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
        end
        check("t3_extra_valids", 64'(nv), 64'(0));
        check("t3_busy_idle", 64'(busy), 64'(0));

        // 4: gate 0 runs as a single cycle
        half_per = 1;
        repeat (4) @(negedge clk);
        run(0, 1'b0, 1, s);
        wait_valid(10, v);
        check("t4_latency", 64'(v - s), 64'(2));
        half_per = 0;
        osc_lvl = 1'b0;
        repeat (6) @(negedge clk);
        run(0, 1'b0, 1, s);
        wait_valid(10, v);
        check("t4_count_low", 64'(count), 64'(0));

        // 5: stop mid-window; start while busy ignored
        half_per = 1;
        repeat (4) @(negedge clk);
        run(10, 1'b0, 1, s);
        wait_valid(40, v);
        check("t5_prep_count", 64'(count), 64'(5));
        run(10, 1'b0, 1, s);
        wait_until(s + 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(s + 4);
        stop = 1'b1;
        busy_hi = cyc;
        void'(exp_q.pop_front());
        @(negedge clk);
        stop = 1'b0;
        check("t5_busy_after_stop", 64'(busy), 64'(0));
        nv = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
        end
        check("t5_no_valid", 64'(nv), 64'(0));
        check("t5_count_hold", 64'(count), 64'(5));

        // 6: async reset between edges mid-MEASURE, then a fresh run
        run(10, 1'b0, 1, s);
        wait_until(s + 5);
        @(posedge clk);
        #2;
        exp_q.delete();
        last_count = 0;
        last_ovf = 1'b0;
        busy_hi = -1;
        rst = 1'b1;
        #1;
        check("t6_rst_count", 64'(count), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_valid", 64'(valid), 64'(0));
        check("t6_rst_overflow", 64'(overflow), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run(10, 1'b0, 1, s);
        wait_valid(40, v);
        check("t6_latency", 64'(v - s), 64'(11));
        check("t6_count", 64'(count), 64'(5));
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/osc_freq_counter.md
Name: osc_freq_counter

Overview:
Parametrised successor to the 8-bit free-running counter. It is a gated edge counter that measures ring-oscillator frequency. The asynchronous oscillator output is synchronised into the clk domain, its rising edges are counted over a programmable window of clk cycles, and the result is latched with a valid pulse. It sits between the ring oscillator and the readout logic and supports single-shot and continuous modes, saturation and abort.

Parameters:
CNT_WIDTH, 8, width of edge count result
GATE_WIDTH, 16, width of window length in clk cycles
SYNC_STAGES, 2, synchroniser flops on osc_in (legal >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
osc_in  input  1  ring-oscillator output, asynchronous to clk
start  input  1  request a measurement; sampled only when busy=0
continuous  input  1  1 = re-arm automatically after each window
gate_len  input  GATE_WIDTH  window length in clk cycles; latched at window start
stop  input  1  abort the current measurement
busy  output  1  high in ARM or MEASURE
count  output  CNT_WIDTH  edges counted in the last completed window
valid  output  1  one-cycle pulse when count/overflow update
overflow  output  1  last window saturated

Behaviour:
- Reset (async, any time): state=IDLE; count=0, valid=0, overflow=0, busy=0; synchroniser, edge history, timer and accumulator are cleared.
- Synchroniser: SYNC_STAGES-flop chain on osc_in gives s. prev is s delayed one cycle. edge = s & ~prev.
- States: IDLE, ARM, MEASURE.
- IDLE: start=1 -> ARM. Latch gate_len into timer; a gate_len of 0 is latched as 1.
- ARM: lasts 1 cycle. Load prev=s, clear acc and ovf; no counting. Then -> MEASURE.
- MEASURE: lasts exactly the latched gate_len cycles. Each cycle with edge=1 does acc+1.
  - acc saturates at 2^CNT_WIDTH-1; an edge at saturation sets ovf.
  - timer decrements each cycle.
- Final MEASURE cycle (timer==1): next cycle count = acc including that cycle's edge, overflow = ovf, valid = 1 for one cycle.
  - continuous=1: next state MEASURE directly with no ARM and no gap. Relatch gate_len (0 -> 1) and clear acc/ovf. An edge on the boundary cycle belongs to the old window.
  - continuous=0: -> IDLE.
- start while busy=1: ignored.
- continuous cleared mid-window: the current window completes normally, then -> IDLE.
- stop=1 in ARM or MEASURE: -> IDLE next cycle; valid not pulsed; count/overflow keep their previous values. stop has priority over window completion in the same cycle. stop in IDLE has no effect.
- start and stop together in IDLE: start wins, stop ignored.
- busy: registered; equals 1 exactly in the cycles where state is ARM or MEASURE.
- count/overflow: change only on valid cycles.
- Latency from start: valid asserts gate_len+2 cycles after the start cycle.

Decomposition:
- Package osc_freq_pkg holds:
  - state enum (IDLE, ARM, MEASURE);
  - function sat_inc(acc) returning {ovf, acc'};
  - constant CNT_MAX.
- Sub-module edge_sync_detect (param SYNC_STAGES): ports clk, rst, async_in, edge_out, level_out, plus a clear input that loads prev. It is reused by other ring-oscillator blocks.
- The top module holds the FSM, timer, accumulator and output registers.

Test Plan:
1. osc_in toggles every clk (rising edge every 2 cycles), gate_len=10, start pulse, continuous=0 -> valid once at start+12, count=5, overflow=0, busy low afterwards.
2. Same oscillator, CNT_WIDTH=8, gate_len=600 -> count=255, overflow=1. Next run with gate_len=20 -> count=10, overflow=0.
3. continuous=1, gate_len=8, oscillator with period 4 clk -> valid every 8 cycles back-to-back, each count=2. Clear continuous mid-window -> exactly one further valid, then IDLE.
4. gate_len=0 -> treated as 1: valid at start+3; count is 0 or 1, matching the edge in the single window cycle. osc_in held low -> count=0.
5. stop asserted 4 cycles into a gate_len=10 run -> no valid, count holds previous value, busy=0 next cycle. A start during busy is ignored: no second valid, no window restart.
6. Async rst asserted mid-MEASURE between clk edges -> outputs immediately 0, state IDLE. After release, a fresh start runs a complete correct measurement.
